spi_xfer_ctrl: RTL and testbench
================================

Name: spi_xfer_ctrl

Overview:
- Master-mode SPI transfer sequencer that drives the byte shift register: it loads the register, generates SCLK from a programmable baud divider, and issues the per-edge drive/sample strobes.
- It frames each byte with slave select and reports completion to the APB register block.
- Sits between the APB register block (mode, baud and start controls) and the shift register / SPI pins.

Parameters:
- LEAD_HALF, 1, SCLK half-periods with ss low before the first SCLK edge (1..4).
- TRAIL_HALF, 1, SCLK half-periods with ss low after the last SCLK edge (1..4).

Ports:
- PCLK  in  1  system clock.
- PRESETn  in  1  asynchronous, active-low reset.
- spe  in  1  SPI enable; low aborts any transfer.
- mstr  in  1  master mode; start is ignored when low.
- cpol  in  1  SCLK idle level.
- cpha  in  1  clock phase.
- sppr  in  3  baud prescaler.
- spr  in  3  baud exponent.
- start  in  1  one-cycle pulse requesting a byte transfer.
- spif_clr  in  1  clears spif.
- ss  out  1  slave select, active low.
- sclk  out  1  SPI clock.
- send_data  out  1  one-cycle load strobe to the shift register.
- receive_data  out  1  one-cycle received-byte valid strobe.
- flags_low, flags_high  out  1 each  drive strobes.
- flag_low, flag_high  out  1 each  sample strobes.
- busy  out  1  transfer in progress.
- spif  out  1  transfer-complete flag (sticky).
- wcol  out  1  one-cycle pulse when start arrives while busy.

Behaviour:
- Reset values: ss=1, sclk=0, busy=0, spif=0; all strobes 0; FSM in IDLE; counters 0.
- Divider:
  - half = (sppr+1) << (spr+1), giving a range of 2..2048 PCLK cycles per half-period. Use a 12-bit counter.
  - sppr, spr, cpol and cpha are latched in LOAD and held for the whole byte.
- States and transitions:
  - IDLE: exits to LOAD on start && spe && mstr.
  - LOAD: 1 cycle. send_data=1; ss goes low.
  - LEAD: LEAD_HALF half-periods; sclk = cpol.
  - XFER: 16 half-periods. sclk toggles at the end of each half-period and starts at cpol.
  - TRAIL: TRAIL_HALF half-periods; sclk = cpol.
  - DONE: 1 cycle. receive_data=1. Next cycle: ss=1, spif=1, return to IDLE.
- busy = 1 in every state except IDLE.
- Strobes are asserted in XFER only. Let c be the half-period counter, counting 0..half-1.
  - flags_* fire at c = half-2 when half > 2; when half = 2 they fire at c = 0.
  - flag_* fire at c = half-1.
  - The *_low variants fire while sclk is low (before a rising edge); the *_high variants fire while sclk is high (before a falling edge).
  - Gating: with w = cpol ^ cpha, only flags_low/flag_low are emitted when w=0, and only flags_high/flag_high when w=1.
  - Exactly 8 drive strobes and 8 sample strobes occur per byte.
- Bit counter: 3 bits, increments on each sample strobe. XFER ends after the 16th half-period, not on the bit counter alone; the bit counter must read 0 (wrapped) on exit.
- spif: set in the cycle after DONE. Cleared by spif_clr. If set and clear coincide, set wins.
- start while busy: ignored, wcol pulses for 1 cycle, the transfer is unaffected. start with spe=0 or mstr=0: ignored, no wcol.
- spe deasserted in any non-IDLE state:
  - next cycle: IDLE, ss=1, sclk=cpol, no receive_data, spif unchanged, counters cleared.
- Asynchronous reset mid-transfer: all outputs take reset values immediately.
- When idle, sclk tracks the live cpol input.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, LEAD, XFER, TRAIL, DONE), the 12-bit divider width, and the 16 half-periods-per-byte constant.
- One sub-module, spi_baud_gen: divider counter, half-period tick, and the c = half-2 / c = half-1 strobe timing. The FSM, ss logic and flags stay in spi_xfer_ctrl.

Test Plan:
- Mode 0, sppr=0, spr=0 (half=2), start at cycle T:
  - send_data at T+1; ss low T+1..T+38; 16 sclk toggles over T+4..T+35.
  - 8 flags_low and 8 flag_low; receive_data at T+38; spif=1 and busy=0 at T+39.
- Modes 1/2/3 at half=2: only the *_high strobes appear when cpol^cpha=1. sclk idles at cpol and ends at cpol. Byte length is again 38 cycles.
- sppr=2, spr=1 (half=12): drive strobe at c=10 and sample strobe at c=11 in each half-period; total transfer = 1+12+192+12+1 cycles.
- start pulsed during XFER: wcol pulses once, still exactly 8 sample strobes, a single receive_data, and no second byte.
- spe dropped at the 5th sample strobe: next cycle ss=1, busy=0, no receive_data, spif stays 0. A new start then runs a full byte.
- spif_clr and the spif set in the same cycle: spif=1. spif_clr alone afterwards: spif=0. PRESETn pulsed mid-XFER: ss=1, sclk=0, all strobes 0 immediately.

Source files
------------

// File: rtl/spi_xfer_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_xfer_ctrl_pkg                                          |
// | Purpose : Shared types and constants for the SPI transfer sequencer: |
// |           FSM state encoding, divider width, half-periods per byte   |
// |           and the baud half-period helper.                           |
// | Ports   : none (package)                                             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package spi_xfer_ctrl_pkg;

  // Divider counter width; covers half-periods of 2..2048 PCLK cycles.
  localparam int C_DIV_W = 12;

  // One byte is 8 SCLK periods, i.e. 16 half-periods.
  localparam int C_HALVES_PER_BYTE = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_LEAD  = 3'd2,
    ST_XFER  = 3'd3,
    ST_TRAIL = 3'd4,
    ST_DONE  = 3'd5
  } xfer_state_t;

  // half = (sppr + 1) << (spr + 1). The shift amount is widened so that
  // spr = 7 yields a shift of 8 instead of wrapping to 0.
  function automatic logic [C_DIV_W-1:0] half_period(input logic [2:0] i_sppr,
                                                     input logic [2:0] i_spr);
    logic [C_DIV_W-1:0] w_base;
    w_base = C_DIV_W'(i_sppr) + C_DIV_W'(1);
    return w_base << ({1'b0, i_spr} + 4'd1);
  endfunction

endpackage : spi_xfer_ctrl_pkg
`default_nettype wire

// File: rtl/spi_baud_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_baud_gen                                               |
// | Purpose : SCLK half-period divider. Counts c = 0..half-1 while       |
// |           enabled and flags the drive point and the end of each      |
// |           half-period (which is also the sample point).              |
// | Ports   : PCLK, PRESETn  - clock, async active-low reset             |
// |           i_en           - run the divider; low holds c at 0         |
// |           i_sppr, i_spr  - latched baud prescaler / exponent         |
// |           o_tick         - c = half-1 (end of half-period, sample)   |
// |           o_drive        - c = half-2 (or c = 0 when half = 2)       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module spi_baud_gen
  import spi_xfer_ctrl_pkg::*;
(
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       i_en,
  input  logic [2:0] i_sppr,
  input  logic [2:0] i_spr,
  output logic       o_tick,
  output logic       o_drive
);

  logic [C_DIV_W-1:0] r_cnt;
  logic [C_DIV_W-1:0] w_half;
  logic [C_DIV_W-1:0] w_last;
  logic [C_DIV_W-1:0] w_drv_pt;

  assign w_half   = half_period(i_sppr, i_spr);
  assign w_last   = w_half - C_DIV_W'(1);
  // With the minimum half-period of 2 there is no c = half-2 slot distinct
  // from the previous sample, so drive moves to the first cycle.
  assign w_drv_pt = (w_half > C_DIV_W'(2)) ? (w_half - C_DIV_W'(2)) : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= '0;
    end else if (!i_en || (r_cnt == w_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + C_DIV_W'(1);
    end
  end

  assign o_tick  = i_en && (r_cnt == w_last);
  assign o_drive = i_en && (r_cnt == w_drv_pt);

endmodule : spi_baud_gen
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_xfer_ctrl                                              |
// | Purpose : Master-mode SPI byte sequencer. Loads the shift register,  |
// |           frames the byte with ss, generates SCLK and issues the     |
// |           per-edge drive/sample strobes; reports completion (spif).  |
// | Ports   : PCLK, PRESETn            - clock, async active-low reset   |
// |           spe, mstr, cpol, cpha    - mode controls                   |
// |           sppr, spr                - baud prescaler / exponent       |
// |           start, spif_clr          - transfer request, flag clear    |
// |           ss, sclk                 - SPI pins                        |
// |           send_data, receive_data  - shift register load / valid     |
// |           flags_low/high           - drive strobes                   |
// |           flag_low/high            - sample strobes                  |
// |           busy, spif, wcol         - status                          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module spi_xfer_ctrl
  import spi_xfer_ctrl_pkg::*;
#(
  parameter int LEAD_HALF  = 1,
  parameter int TRAIL_HALF = 1
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       spe,
  input  logic       mstr,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [2:0] sppr,
  input  logic [2:0] spr,
  input  logic       start,
  input  logic       spif_clr,
  output logic       ss,
  output logic       sclk,
  output logic       send_data,
  output logic       receive_data,
  output logic       flags_low,
  output logic       flags_high,
  output logic       flag_low,
  output logic       flag_high,
  output logic       busy,
  output logic       spif,
  output logic       wcol
);

  localparam logic [3:0] C_LEAD_LAST  = 4'(LEAD_HALF - 1);
  localparam logic [3:0] C_TRAIL_LAST = 4'(TRAIL_HALF - 1);
  localparam logic [3:0] C_XFER_LAST  = 4'(C_HALVES_PER_BYTE - 1);

  xfer_state_t r_state;
  xfer_state_t w_state_nxt;

  logic       r_cpol, r_cpha;
  logic [2:0] r_sppr, r_spr;
  logic [3:0] r_hcnt;
  logic       r_phase;
  logic [2:0] r_bitcnt;
  logic       r_spif;
  logic       r_wcol;

  logic       w_tick, w_drive, w_div_en, w_abort;
  logic       w_in_xfer, w_lvl, w_w, w_side;
  logic       w_sample_any;
  logic [2:0] w_bitcnt_nxt;

  assign w_abort  = (r_state != ST_IDLE) && !spe;
  assign w_div_en = spe && ((r_state == ST_LEAD) || (r_state == ST_XFER) ||
                            (r_state == ST_TRAIL));

  spi_baud_gen u_baud (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .i_en    (w_div_en),
    .i_sppr  (r_sppr),
    .i_spr   (r_spr),
    .o_tick  (w_tick),
    .o_drive (w_drive)
  );

  // Current SCLK level inside XFER and the edge family selected by the mode.
  // Strobes are emitted only in half-periods whose level matches w.
  assign w_in_xfer    = (r_state == ST_XFER) && spe;
  assign w_lvl        = r_cpol ^ r_phase;
  assign w_w          = r_cpol ^ r_cpha;
  assign w_side       = w_in_xfer && (w_lvl == w_w);
  assign w_sample_any = w_side && w_tick;
  assign w_bitcnt_nxt = r_bitcnt + (w_sample_any ? 3'd1 : 3'd0);

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start && spe && mstr) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_LEAD;
      ST_LEAD:  if (w_tick && (r_hcnt == C_LEAD_LAST)) w_state_nxt = ST_XFER;
      // Length is set by the half-period count; the wrapped bit counter
      // must agree, so a miscounted byte stays visible instead of ending.
      ST_XFER:  if (w_tick && (r_hcnt == C_XFER_LAST) && (w_bitcnt_nxt == 3'd0))
                  w_state_nxt = ST_TRAIL;
      ST_TRAIL: if (w_tick && (r_hcnt == C_TRAIL_LAST)) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_state_nxt = ST_IDLE;
  end

  // Outputs
  always_comb begin
    ss           = (r_state == ST_IDLE);
    busy         = (r_state != ST_IDLE);
    send_data    = (r_state == ST_LOAD);
    receive_data = (r_state == ST_DONE) && spe;
    case (r_state)
      ST_IDLE, ST_LOAD: sclk = cpol;
      ST_XFER:          sclk = w_lvl;
      default:          sclk = r_cpol;
    endcase
    flags_low  = w_side && w_drive && !w_w;
    flag_low   = w_side && w_tick  && !w_w;
    flags_high = w_side && w_drive &&  w_w;
    flag_high  = w_side && w_tick  &&  w_w;
    spif       = r_spif;
    wcol       = r_wcol;
  end

  // Datapath: mode latch, half-period / bit counters, SCLK phase, flags
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_sppr   <= 3'd0;
      r_spr    <= 3'd0;
      r_hcnt   <= 4'd0;
      r_phase  <= 1'b0;
      r_bitcnt <= 3'd0;
      r_spif   <= 1'b0;
      r_wcol   <= 1'b0;
    end else begin
      r_wcol <= start && spe && mstr && (r_state != ST_IDLE);

      if (r_state == ST_LOAD) begin
        r_cpol <= cpol;
        r_cpha <= cpha;
        r_sppr <= sppr;
        r_spr  <= spr;
      end

      // Half-periods are counted per state and restart on every transition.
      if (w_abort || (r_state == ST_IDLE) || (r_state == ST_LOAD) ||
          (r_state == ST_DONE)) begin
        r_hcnt <= 4'd0;
      end else if (w_tick) begin
        r_hcnt <= (w_state_nxt != r_state) ? 4'd0 : (r_hcnt + 4'd1);
      end

      if (w_in_xfer) begin
        if (w_tick) r_phase <= ~r_phase;
      end else begin
        r_phase <= 1'b0;
      end

      if (w_abort || (r_state == ST_IDLE)) begin
        r_bitcnt <= 3'd0;
      end else if (w_sample_any) begin
        r_bitcnt <= w_bitcnt_nxt;
      end

      // Set has priority over a coincident clear.
      if ((r_state == ST_DONE) && spe) begin
        r_spif <= 1'b1;
      end else if (spif_clr) begin
        r_spif <= 1'b0;
      end
    end
  end

endmodule : spi_xfer_ctrl
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_spi_xfer_ctrl                                           |
// | Purpose : Self-checking bench for spi_xfer_ctrl: table of byte modes |
// |           with a scoreboard of expected frames, plus hand sequences  |
// |           for collision, abort, flag and reset corner cases.         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_spi_xfer_ctrl;

  localparam int LEAD = 1;

  logic       PCLK, PRESETn, spe, mstr, cpol, cpha, start, spif_clr;
  logic [2:0] sppr, spr;
  logic       ss, sclk, send_data, receive_data;
  logic       flags_low, flags_high, flag_low, flag_high, busy, spif, wcol;

  spi_xfer_ctrl #(.LEAD_HALF(1), .TRAIL_HALF(1)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .spe(spe), .mstr(mstr), .cpol(cpol),
    .cpha(cpha), .sppr(sppr), .spr(spr), .start(start), .spif_clr(spif_clr),
    .ss(ss), .sclk(sclk), .send_data(send_data), .receive_data(receive_data),
    .flags_low(flags_low), .flags_high(flags_high), .flag_low(flag_low),
    .flag_high(flag_high), .busy(busy), .spif(spif), .wcol(wcol)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    bit       cpol;
    bit       cpha;
    bit [2:0] sppr;
    bit [2:0] spr;
    int       half;
    int       len;  // LOAD..DONE cycles
    bit       hi;   // 1: only *_high strobes expected
  } vec_t;

  typedef struct {
    int len;
    bit hi;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[8];

  int tests, fails;
  int cyc, s_cyc;
  bit in_byte;
  int nd_ok, nd_bad, ns_ok, ns_bad, ntog, perr, stray;
  bit prev_sclk;
  int n_recv, n_wcol, n_send, n_abort;
  int cur_h;
  bit cur_cpol, cur_hi;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample everything at the falling edge and update the monitor.
  task automatic step();
    int k, xs, xe, c, dpos, hp;
    bit in_x, exp_s;
    exp_t e;
    @(negedge PCLK);
    cyc++;
    if (wcol) n_wcol++;
    if (receive_data) n_recv++;
    if (send_data) begin
      n_send++;
      s_cyc = cyc; in_byte = 1'b1;
      nd_ok = 0; nd_bad = 0; ns_ok = 0; ns_bad = 0; ntog = 0; perr = 0;
      prev_sclk = sclk;
      if (sclk !== cur_cpol) perr++;
    end else if (in_byte && ss) begin
      in_byte = 1'b0;
      n_abort++;
    end
    k = cyc - s_cyc;
    xs = 1 + LEAD * cur_h;
    xe = xs + 16 * cur_h;
    in_x = in_byte && (k >= xs) && (k < xe);
    c = in_x ? (k - xs) % cur_h : -1;
    hp = in_x ? (k - xs) / cur_h : 0;
    dpos = (cur_h > 2) ? cur_h - 2 : 0;
    if (in_byte && !send_data) begin
      exp_s = in_x ? (cur_cpol ^ hp[0]) : cur_cpol;
      if (sclk !== exp_s) perr++;
      if (sclk !== prev_sclk) ntog++;
      prev_sclk = sclk;
    end
    if (in_byte) begin
      if (flags_low)  begin if (!cur_hi && in_x && c == dpos && !sclk) nd_ok++; else nd_bad++; end
      if (flags_high) begin if ( cur_hi && in_x && c == dpos &&  sclk) nd_ok++; else nd_bad++; end
      if (flag_low)   begin if (!cur_hi && in_x && c == cur_h-1 && !sclk) ns_ok++; else ns_bad++; end
      if (flag_high)  begin if ( cur_hi && in_x && c == cur_h-1 &&  sclk) ns_ok++; else ns_bad++; end
    end else if (flags_low || flags_high || flag_low || flag_high) begin
      stray++;
    end
    if (receive_data) begin
      if (sbq.size() == 0) begin
        chk("unexpected_receive_data", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("byte_len", k + 1, e.len);
        chk("drive_strobes", nd_ok, 8);
        chk("sample_strobes", ns_ok, 8);
        chk("misplaced_strobes", nd_bad + ns_bad, 0);
        chk("sclk_toggles", ntog, 16);
        chk("frame_errors", perr, 0);
      end
      in_byte = 1'b0;
    end
  endtask

  task automatic set_mode(input vec_t v);
    cpol = v.cpol; cpha = v.cpha; sppr = v.sppr; spr = v.spr;
    cur_h = v.half; cur_cpol = v.cpol; cur_hi = v.hi;
  endtask

  task automatic run_byte(input vec_t v, input int wcol_at, input bit clr_on_done);
    int r0, w0, s0;
    bit done;
    set_mode(v);
    spe = 1'b1; mstr = 1'b1;
    step();
    chk("idle_sclk_tracks_cpol", sclk, v.cpol);
    r0 = n_recv; w0 = n_wcol; s0 = n_send;
    sbq.push_back('{len: v.len, hi: v.hi});
    start = 1'b1;
    step();
    start = 1'b0;
    chk("send_data_latency", send_data, 1);
    chk("ss_low_in_load", ss, 0);
    done = 1'b0;
    for (int i = 1; i < 6000; i++) begin
      step();
      start    = (i == wcol_at);
      spif_clr = clr_on_done && receive_data;
      if (!busy) begin done = 1'b1; break; end
    end
    start = 1'b0; spif_clr = 1'b0;
    chk("byte_timeout", done, 1);
    chk("spif_after_done", spif, 1);
    chk("ss_after_done", ss, 1);
    chk("receive_count", n_recv - r0, 1);
    chk("wcol_count", n_wcol - w0, (wcol_at > 0) ? 1 : 0);
    chk("scoreboard_drained", sbq.size(), 0);
    spif_clr = 1'b1;
    step();
    spif_clr = 1'b0;
    chk("spif_cleared", spif, 0);
    repeat (4) step();
    chk("no_second_byte", n_send - s0, 1);
    chk("idle_not_busy", busy, 0);
  endtask

  task automatic try_ignored(input bit e_spe, input bit e_mstr);
    int s0, w0;
    s0 = n_send; w0 = n_wcol;
    spe = e_spe; mstr = e_mstr;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("ignored_start_send", n_send - s0, 0);
    chk("ignored_start_busy", busy, 0);
    chk("ignored_start_wcol", n_wcol - w0, 0);
    spe = 1'b1; mstr = 1'b1;
  endtask

  initial begin
    int r0, a0;
    bit hit;
    tests = 0; fails = 0; cyc = 0; s_cyc = 0; in_byte = 1'b0; stray = 0;
    n_recv = 0; n_wcol = 0; n_send = 0; n_abort = 0;
    nd_ok = 0; nd_bad = 0; ns_ok = 0; ns_bad = 0; ntog = 0; perr = 0;
    prev_sclk = 1'b0; cur_h = 2; cur_cpol = 1'b0; cur_hi = 1'b0;

    //            cpol cpha sppr  spr   half  len   hi
    vecs[0] = '{1'b0, 1'b0, 3'd0, 3'd0,    2,   38, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 3'd0, 3'd0,    2,   38, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 3'd0, 3'd0,    2,   38, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 3'd0, 3'd0,    2,   38, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 3'd2, 3'd1,   12,  218, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 3'd1, 3'd0,    4,   74, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 3'd7, 3'd0,   16,  290, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 3'd0, 3'd7,  256, 4610, 1'b0};

    PRESETn = 1'b0; spe = 1'b0; mstr = 1'b0; cpol = 1'b0; cpha = 1'b0;
    sppr = 3'd0; spr = 3'd0; start = 1'b0; spif_clr = 1'b0;
    #22;
    chk("reset_ss", ss, 1);
    chk("reset_sclk", sclk, 0);
    chk("reset_busy", busy, 0);
    chk("reset_spif", spif, 0);
    chk("reset_strobes", {send_data, receive_data, flags_low, flags_high,
                          flag_low, flag_high, wcol}, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    step();

    // Table-driven bytes in every mode and several baud settings.
    foreach (vecs[i]) run_byte(vecs[i], 0, 1'b0);

    // start with spe=0 or mstr=0 does nothing.
    try_ignored(1'b0, 1'b1);
    try_ignored(1'b1, 1'b0);

    // start during XFER: one wcol, byte unaffected.
    run_byte(vecs[0], 10, 1'b0);

    // spif_clr coinciding with the set: set wins, then a lone clear works.
    run_byte(vecs[0], 0, 1'b1);

    // spe dropped at the 5th sample strobe.
    set_mode(vecs[0]);
    spe = 1'b1; mstr = 1'b1;
    r0 = n_recv; a0 = n_abort;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ns_ok == 5) begin hit = 1'b1; break; end
    end
    chk("abort_point_reached", hit, 1);
    spe = 1'b0;
    step();
    chk("abort_ss", ss, 1);
    chk("abort_busy", busy, 0);
    chk("abort_sclk", sclk, 0);
    repeat (3) step();
    chk("abort_no_receive", n_recv - r0, 0);
    chk("abort_spif", spif, 0);
    chk("abort_seen", n_abort - a0, 1);
    run_byte(vecs[0], 0, 1'b0);

    // Asynchronous reset while a drive strobe is active in XFER.
    set_mode(vecs[4]);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (flags_low && (cyc - s_cyc) > 20 && !sclk) begin hit = 1'b1; break; end
    end
    chk("reset_point_reached", hit, 1);
    #1 PRESETn = 1'b0;
    #1;
    chk("async_reset_ss", ss, 1);
    chk("async_reset_sclk", sclk, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_strobes", {send_data, receive_data, flags_low, flags_high,
                                flag_low, flag_high}, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (3) step();
    chk("post_reset_idle", busy, 0);
    chk("stray_strobes", stray, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_spi_xfer_ctrl
`default_nettype wire
